tfp2fix_stream: RTL and testbench
=================================

// Module: tfp2fix_stream
// PURPOSE
//  Multi-channel trivial float-point to fixed-point converter with valid/ready streaming and backpressure.
//  TFP word = {signed mantissa [TFP_WIDTH-1:EXP_WIDTH], unsigned exponent [EXP_WIDTH-1:0]}; value = mantissa << exponent.
//  Result is narrowed to FIX_WIDTH with overflow detection. Sits between ADC/DSP front-ends and fixed-point datapaths.
// PARAMETERS
//  CHANNELS   1   number of parallel lanes sharing one handshake
//  TFP_WIDTH  8   width of one TFP word
//  EXP_WIDTH  3   width of exponent field
//  FIX_WIDTH  TFP_WIDTH-EXP_WIDTH+2**EXP_WIDTH-1   output width per lane; may be less than the full width FULL_W (same formula)
//  PIPELINE   1   register stages, >= 1
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     asynchronous reset, active-high
//  clkena     in   1                     global enable; 0 freezes all state
//  i_data     in   CHANNELS*TFP_WIDTH    input TFP words, lane k at [k*TFP_WIDTH +: TFP_WIDTH]
//  i_valid    in   1                     input beat valid
//  i_ready    out  1                     input beat accepted when i_valid & i_ready
//  o_data     out  CHANNELS*FIX_WIDTH    fixed-point results, same lane packing
//  o_ovf      out  CHANNELS              per-lane overflow flag, in-band with o_data
//  o_valid    out  1                     output beat valid
//  o_ready    in   1                     downstream accept
//  ovf_clr    in   1                     clears sticky overflow status
//  ovf_sticky out  CHANNELS              per-lane sticky overflow since last clear
// BEHAVIOUR
//  Reset: o_data=0, o_ovf=0, o_valid=0, ovf_sticky=0, all stage valids=0. Reset mid-stream discards all in-flight beats.
//  Conversion (stage-0 input, combinational):
//   full = sign_extend(mantissa, FULL_W) << exponent, computed in FULL_W bits.
//   ovf  = FIX_WIDTH<FULL_W and full[FULL_W-1:FIX_WIDTH-1] not all equal.
//   FIX_WIDTH>=FULL_W: sign-extend full, ovf=0.
//  Pipeline: stage s has valid v[s] and data; adv[s] = clkena & (~v[s] | adv[s+1]); adv[last] = clkena & (~v[last] | o_ready).
//   i_ready = adv[0]; the o_ready -> i_ready path is combinational by design.
//   Stage loads upstream beat (or bubble) when adv[s]; holds data/valid otherwise.
//  Latency exactly PIPELINE cycles with o_ready=1; full throughput of one beat per cycle.
//  AXI-style rules: o_data/o_ovf stable while o_valid & ~o_ready; o_valid never drops without a handshake.
//  Full: all stages valid and o_ready=0 -> i_ready=0. Empty: o_valid=0, i_ready=clkena.
//  clkena=0: i_ready=0; outputs and ovf_sticky hold; ovf_clr ignored.
//  Sticky: on output handshake, ovf_sticky |= o_ovf. ovf_clr=1 clears it. Same-cycle clear and set -> set wins (bit=1).
// CONFIGURATION
//  Macro TFP2FIX_STREAM_SAT_EN.
//   Defined: on ovf, lane output saturates to +(2**(FIX_WIDTH-1)-1) or -(2**(FIX_WIDTH-1)) by sign of full.
//   Undefined: lane output = full[FIX_WIDTH-1:0] (wrap); ovf still reported.
// STRUCTURE
//  Package tfp2fix_pkg:
//   function tfp2fix_full_width(tfp_w, exp_w);
//   localparam FULL_W;
//   lane result struct {fix, ovf}.
//  Sub-module tfp2fix_lane: combinational per-lane convert + ovf + optional saturation, instantiated CHANNELS times.
//  Top holds the handshake pipeline and sticky status.
// TESTING (CHANNELS=2, TFP_WIDTH=8, EXP_WIDTH=3, FULL_W=12, FIX_WIDTH=10, PIPELINE=2)
//  In-range: lane0=8'b00011_010 (3<<2), lane1=8'b11111_000 (-1) -> o_data={10'h3FF,10'h00C}, o_ovf=0, 2 cycles later.
//  Overflow, SAT_EN: 8'b01111_111 (1920) -> 10'h1FF, ovf=1; 8'b10000_111 (-2048) -> 10'h200, ovf=1.
//  Overflow, no SAT_EN: 8'b01111_111 -> 10'h380, ovf=1.
//  Backpressure: 6 beats back-to-back, o_ready=0 for cycles 3-7 -> i_ready=0 after 2 beats buffered, no loss/dup, order kept, o_data stable.
//  Sticky: ovf beat accepted -> ovf_sticky=1; ovf_clr with new ovf beat same cycle -> stays 1; ovf_clr alone -> 0.
//  rst asserted with 2 beats in flight -> o_valid=0 next edge-independent; no stale beat emerges after release.

Source files
------------

// File: rtl/tfp2fix_pkg.sv
// Shared types and helpers for the TFP to fixed-point stream converter.
// Full-width formula is reused by the lane and the top-level defaults.
package tfp2fix_pkg;

  function automatic int tfp2fix_full_width(input int tfp_w, input int exp_w);
    return tfp_w - exp_w + (2 ** exp_w) - 1;
  endfunction

  localparam int FULL_W = tfp2fix_full_width(8, 3);

  typedef struct packed {
    logic [FULL_W-1:0] fix;
    logic              ovf;
  } lane_res_t;

endpackage

// File: rtl/tfp2fix_lane.sv
// Combinational single-lane TFP to fixed-point conversion with overflow.
// TFP2FIX_STREAM_SAT_EN selects saturation instead of wrap on overflow.
module tfp2fix_lane
  import tfp2fix_pkg::*;
#(
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int FIX_WIDTH = tfp2fix_full_width(TFP_WIDTH, EXP_WIDTH)
) (
  input  logic [TFP_WIDTH-1:0] tfp_i,
  output logic [FIX_WIDTH-1:0] fix_o,
  output logic                 ovf_o
);

  localparam int FW = tfp2fix_full_width(TFP_WIDTH, EXP_WIDTH);
  localparam int MW = TFP_WIDTH - EXP_WIDTH;

  logic [MW-1:0]        mant;
  logic [EXP_WIDTH-1:0] ex;
  logic [FW-1:0]        full;

  assign mant = tfp_i[TFP_WIDTH-1:EXP_WIDTH];
  assign ex   = tfp_i[EXP_WIDTH-1:0];
  assign full = {{(FW-MW){mant[MW-1]}}, mant} << ex;

  generate
    if (FIX_WIDTH < FW) begin : g_narrow
      // Bits that are dropped plus the new sign must all match.
      logic [FW-FIX_WIDTH:0] top;
      logic                  ovf;
      assign top   = full[FW-1:FIX_WIDTH-1];
      assign ovf   = ~(&top | ~|top);
      assign ovf_o = ovf;
`ifdef TFP2FIX_STREAM_SAT_EN
      logic [FIX_WIDTH-1:0] sat;
      assign sat = full[FW-1] ?
        {1'b1, {(FIX_WIDTH-1){1'b0}}} :
        {1'b0, {(FIX_WIDTH-1){1'b1}}};
      assign fix_o = ovf ? sat : full[FIX_WIDTH-1:0];
`else
      assign fix_o = full[FIX_WIDTH-1:0];
`endif
    end else begin : g_wide
      assign fix_o = FIX_WIDTH'($signed(full));
      assign ovf_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/tfp2fix_stream.sv
// Multi-lane TFP to fixed-point converter with valid/ready pipeline.
// Optional saturation via TFP2FIX_STREAM_SAT_EN (see tfp2fix_lane).
module tfp2fix_stream
  import tfp2fix_pkg::*;
#(
  parameter int CHANNELS  = 1,
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int FIX_WIDTH = tfp2fix_full_width(TFP_WIDTH, EXP_WIDTH),
  parameter int PIPELINE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clkena,
  input  logic [CHANNELS*TFP_WIDTH-1:0] i_data,
  input  logic                          i_valid,
  output logic                          i_ready,
  output logic [CHANNELS*FIX_WIDTH-1:0] o_data,
  output logic [CHANNELS-1:0]           o_ovf,
  output logic                          o_valid,
  input  logic                          o_ready,
  input  logic                          ovf_clr,
  output logic [CHANNELS-1:0]           ovf_sticky
);

  localparam int LAST = PIPELINE - 1;

  logic [CHANNELS*FIX_WIDTH-1:0] lane_fix;
  logic [CHANNELS-1:0]           lane_ovf;

  logic [PIPELINE-1:0]           v_q;
  logic [PIPELINE-1:0]           adv;
  logic [CHANNELS*FIX_WIDTH-1:0] d_q   [PIPELINE];
  logic [CHANNELS-1:0]           ovf_q [PIPELINE];
  logic [CHANNELS-1:0]           sticky_q, sticky_d;
  logic                          full_run;
  logic                          hs;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      tfp2fix_lane #(
        .TFP_WIDTH(TFP_WIDTH),
        .EXP_WIDTH(EXP_WIDTH),
        .FIX_WIDTH(FIX_WIDTH)
      ) u_lane (
        .tfp_i(i_data[k*TFP_WIDTH +: TFP_WIDTH]),
        .fix_o(lane_fix[k*FIX_WIDTH +: FIX_WIDTH]),
        .ovf_o(lane_ovf[k])
      );
    end
  endgenerate

  // A stage may advance unless it and every stage after it is full
  // and the sink is stalling.
  always_comb begin
    adv      = '0;
    full_run = ~o_ready;
    for (int s = LAST; s >= 0; s--) begin
      full_run = full_run & v_q[s];
      adv[s]   = clkena & ~full_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int s = 0; s < PIPELINE; s++) begin
        d_q[s]   <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0]   <= i_valid;
        d_q[0]   <= lane_fix;
        ovf_q[0] <= lane_ovf;
      end
      for (int s = 1; s < PIPELINE; s++) begin
        if (adv[s]) begin
          v_q[s]   <= v_q[s-1];
          d_q[s]   <= d_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
    end
  end

  assign hs = clkena & v_q[LAST] & o_ready;

  always_comb begin
    sticky_d = sticky_q;
    if (clkena) begin
      if (ovf_clr) sticky_d = '0;
      if (hs)      sticky_d = sticky_d | ovf_q[LAST];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign i_ready    = adv[0];
  assign o_valid    = v_q[LAST];
  assign o_data     = d_q[LAST];
  assign o_ovf      = ovf_q[LAST];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_tfp2fix_stream.sv
// Directed bench for tfp2fix_stream: 2 lanes, 8-bit TFP, 10-bit out, 2 stages.
// Expected values follow TFP2FIX_STREAM_SAT_EN when it is defined.
module tb_tfp2fix_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkena;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic [19:0] o_data;
  logic [1:0]  o_ovf;
  logic        o_valid;
  logic        o_ready;
  logic        ovf_clr;
  logic [1:0]  ovf_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tfp2fix_stream #(
    .CHANNELS(2), .TFP_WIDTH(8), .EXP_WIDTH(3),
    .FIX_WIDTH(10), .PIPELINE(2)
  ) dut (
    .clk(clk), .rst(rst), .clkena(clkena),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ovf(o_ovf), .o_valid(o_valid),
    .o_ready(o_ready), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  function automatic logic [7:0] tfp(input int m, input int e);
    logic [4:0] mm;
    logic [2:0] ee;
    mm = m[4:0];
    ee = e[2:0];
    return {mm, ee};
  endfunction

  function automatic logic [9:0] f10(input int v);
    return v[9:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef TFP2FIX_STREAM_SAT_EN
  localparam logic [9:0] POS_OVF = 10'h1FF;
  localparam logic [9:0] NEG_OVF = 10'h200;
`else
  localparam logic [9:0] POS_OVF = 10'h380;
  localparam logic [9:0] NEG_OVF = 10'h000;
`endif

  int         nin, nout;
  logic       prev_hold;
  logic [19:0] prev_data;

  initial begin
    rst = 1'b1; clkena = 1'b1; i_data = '0; i_valid = 1'b0;
    o_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    check("rst_ovalid", {31'b0, o_valid}, 0);
    check("rst_odata", {12'b0, o_data}, 0);
    check("rst_oovf", {30'b0, o_ovf}, 0);
    check("rst_sticky", {30'b0, ovf_sticky}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("empty_irdy", {31'b0, i_ready}, 1);
    clkena = 1'b0; #1;
    check("noena_irdy", {31'b0, i_ready}, 0);
    clkena = 1'b1;

    // In-range beat, latency 2
    i_data = {tfp(-1, 0), tfp(3, 2)}; i_valid = 1'b1; #1;
    check("inr_irdy", {31'b0, i_ready}, 1);
    tick(); i_valid = 1'b0;
    check("inr_lat1", {31'b0, o_valid}, 0);
    tick();
    check("inr_valid", {31'b0, o_valid}, 1);
    check("inr_data", {12'b0, o_data}, {12'b0, 10'h3FF, 10'h00C});
    check("inr_ovf", {30'b0, o_ovf}, 0);
    tick();
    check("inr_drain", {31'b0, o_valid}, 0);

    // Overflow both lanes, held at output
    o_ready = 1'b0;
    i_data = {tfp(-16, 7), tfp(15, 7)}; i_valid = 1'b1;
    tick(); i_valid = 1'b0; tick();
    check("ovf_valid", {31'b0, o_valid}, 1);
    check("ovf_data", {12'b0, o_data}, {12'b0, NEG_OVF, POS_OVF});
    check("ovf_flags", {30'b0, o_ovf}, 2'b11);
    check("ovf_nohs_sticky", {30'b0, ovf_sticky}, 0);
    clkena = 1'b0; o_ready = 1'b1; ovf_clr = 1'b1; #1;
    check("frz_irdy", {31'b0, i_ready}, 0);
    tick();
    check("frz_valid", {31'b0, o_valid}, 1);
    check("frz_sticky", {30'b0, ovf_sticky}, 0);
    clkena = 1'b1; ovf_clr = 1'b0;
    tick();
    check("ovf_sticky_set", {30'b0, ovf_sticky}, 2'b11);
    check("ovf_consumed", {31'b0, o_valid}, 0);
    clkena = 1'b0; ovf_clr = 1'b1;
    tick();
    check("frz_clr_ignored", {30'b0, ovf_sticky}, 2'b11);
    clkena = 1'b1;
    tick();
    check("clr_all", {30'b0, ovf_sticky}, 0);
    ovf_clr = 1'b0;

    // Sticky: set, then clear + set same cycle, then clear alone
    i_data = {tfp(1, 0), tfp(15, 7)}; i_valid = 1'b1;
    tick(); i_valid = 1'b0; tick();
    check("st_data", {12'b0, o_data}, {12'b0, 10'h001, POS_OVF});
    tick();
    check("st_set", {30'b0, ovf_sticky}, 2'b01);
    o_ready = 1'b0; i_valid = 1'b1;
    tick(); i_valid = 1'b0; tick();
    check("st_held", {31'b0, o_valid}, 1);
    o_ready = 1'b1; ovf_clr = 1'b1;
    tick();
    check("st_clr_set_wins", {30'b0, ovf_sticky}, 2'b01);
    tick();
    check("st_clr_alone", {30'b0, ovf_sticky}, 0);
    ovf_clr = 1'b0;

    // Backpressure: 6 beats, stall on cycles 3..7
    nin = 0; nout = 0; prev_hold = 1'b0; prev_data = '0;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      i_valid = (nin < 6);
      i_data  = {tfp(-(nin + 1), 0), tfp(nin + 1, 0)};
      o_ready = !(c >= 3 && c <= 7);
      #1;
      if (c == 5) check("bp_full_irdy", {31'b0, i_ready}, 0);
      if (prev_hold) check("bp_stable", {12'b0, o_data}, {12'b0, prev_data});
      if (o_valid && o_ready) begin
        check("bp_data", {12'b0, o_data},
              {12'b0, f10(-(nout + 1)), f10(nout + 1)});
        nout++;
      end
      if (i_valid && i_ready) nin++;
      prev_hold = o_valid && !o_ready;
      prev_data = o_data;
      tick();
    end
    i_valid = 1'b0;
    check("bp_out_count", nout, 6);
    check("bp_in_count", nin, 6);
    #1;
    check("bp_no_dup", {31'b0, o_valid}, 0);

    // Reset with two beats in flight
    o_ready = 1'b0;
    i_data = {tfp(2, 1), tfp(5, 1)}; i_valid = 1'b1;
    tick(); tick();
    i_valid = 1'b0;
    check("rf_loaded", {31'b0, o_valid}, 1);
    #2 rst = 1'b1; #1;
    check("rf_async_valid", {31'b0, o_valid}, 0);
    check("rf_async_data", {12'b0, o_data}, 0);
    tick();
    rst = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rf_no_stale", {31'b0, o_valid}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
